// File: rtl/core_pkg.sv
// Shared writeback types and constants.
//   wb_req_t              : one register-file write request (file, register, data)
//   REG_ZERO              : general-register index that is hard-wired to zero
//   STARVE_LIMIT_DEFAULT  : default number of wait cycles before a held result is starved
//   is_greg_zero()        : true when a (file, register) pair names general r0
package core_pkg;

  localparam logic [4:0] REG_ZERO             = 5'd0;
  localparam int         STARVE_LIMIT_DEFAULT = 4;

  typedef struct packed {
    logic        fmode;
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_req_t;

  function automatic logic is_greg_zero(input logic fmode, input logic [4:0] rd);
    return (fmode == 1'b0) && (rd == REG_ZERO);
  endfunction

endpackage

// File: rtl/wb_hold_slot.sv
// One-entry holding register for a handshaked writeback source.
//   clk, rstn    : clock, asynchronous active-low reset
//   in_valid_i   : source offers a result
//   in_req_i     : offered result
//   grant_i      : arbiter writes the held entry this cycle
//   ready_o      : slot can take the offered result this cycle
//   hold_v_o     : entry is valid
//   hold_o       : held result
//   starved_o    : entry has waited at least STARVE_LIMIT cycles
module wb_hold_slot
  import core_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT,
  parameter int CNT_W        = 3
) (
  input  logic    clk,
  input  logic    rstn,
  input  logic    in_valid_i,
  input  wb_req_t in_req_i,
  input  logic    grant_i,
  output logic    ready_o,
  output logic    hold_v_o,
  output wb_req_t hold_o,
  output logic    starved_o
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic             hold_v_q, hold_v_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  wb_req_t          hold_q;
  logic             accept;

  // A granted entry frees the slot in the same cycle, so a stream can
  // refill it back-to-back at one result per cycle.
  assign ready_o = ~hold_v_q | grant_i;
  assign accept  = in_valid_i & ready_o;

  always_comb begin
    hold_v_d = hold_v_q;
    wait_d   = wait_q;
    if (accept) begin
      hold_v_d = 1'b1;
      wait_d   = '0;
    end else if (grant_i) begin
      hold_v_d = 1'b0;
      wait_d   = '0;
    end else if (hold_v_q && (wait_q < LIMIT)) begin
      wait_d = wait_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hold_v_q <= 1'b0;
      wait_q   <= '0;
    end else begin
      hold_v_q <= hold_v_d;
      wait_q   <= wait_d;
    end
  end

  // Payload is qualified by hold_v_q, so it needs no reset.
  always_ff @(posedge clk) begin
    if (accept) hold_q <= in_req_i;
  end

  assign hold_v_o  = hold_v_q;
  assign hold_o    = hold_q;
  assign starved_o = hold_v_q && (wait_q >= LIMIT);

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter for the single register-file write port.
//   clk, rstn                    : clock, asynchronous active-low reset
//   alu_*                        : single-cycle ALU result, always accepted, top priority
//   mem_* / fpu_*                : handshaked load-unit / FPU results (valid/ready)
//   wenable, wfmode, wreg, wdata : register-file write port
//   stall_req                    : a held result is starved; upstream must bubble the ALU
//   pend_fmode, pend_reg         : hazard query from decode
//   pend_hit                     : a held result targets the queried register
module wb_arbiter
  import core_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT,
  parameter int CNT_W        = 3
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        alu_valid,
  input  logic        alu_fmode,
  input  logic [4:0]  alu_reg,
  input  logic [31:0] alu_data,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic        mem_fmode,
  input  logic [4:0]  mem_reg,
  input  logic [31:0] mem_data,
  input  logic        fpu_valid,
  output logic        fpu_ready,
  input  logic        fpu_fmode,
  input  logic [4:0]  fpu_reg,
  input  logic [31:0] fpu_data,
  output logic        wenable,
  output logic        wfmode,
  output logic [4:0]  wreg,
  output logic [31:0] wdata,
  output logic        stall_req,
  input  logic        pend_fmode,
  input  logic [4:0]  pend_reg,
  output logic        pend_hit
);

  wb_req_t alu_req, mem_req, fpu_req, mem_hold, fpu_hold, win;
  logic    mem_hv, fpu_hv, mem_starved, fpu_starved;
  logic    g_alu, g_mem, g_fpu, has_grant;

  assign alu_req = '{alu_fmode, alu_reg, alu_data};
  assign mem_req = '{mem_fmode, mem_reg, mem_data};
  assign fpu_req = '{fpu_fmode, fpu_reg, fpu_data};

  wb_hold_slot #(.STARVE_LIMIT(STARVE_LIMIT), .CNT_W(CNT_W)) u_mem_slot (
    .clk        (clk),
    .rstn       (rstn),
    .in_valid_i (mem_valid),
    .in_req_i   (mem_req),
    .grant_i    (g_mem),
    .ready_o    (mem_ready),
    .hold_v_o   (mem_hv),
    .hold_o     (mem_hold),
    .starved_o  (mem_starved)
  );

  wb_hold_slot #(.STARVE_LIMIT(STARVE_LIMIT), .CNT_W(CNT_W)) u_fpu_slot (
    .clk        (clk),
    .rstn       (rstn),
    .in_valid_i (fpu_valid),
    .in_req_i   (fpu_req),
    .grant_i    (g_fpu),
    .ready_o    (fpu_ready),
    .hold_v_o   (fpu_hv),
    .hold_o     (fpu_hold),
    .starved_o  (fpu_starved)
  );

  // The ALU is masked during reset so the write port stays quiet.
  // A starved FPU entry jumps ahead of a waiting load; otherwise loads go first.
  assign g_alu     = alu_valid & rstn;
  assign g_fpu     = ~g_alu & fpu_hv & (fpu_starved | ~mem_hv);
  assign g_mem     = ~g_alu & mem_hv & ~(fpu_hv & fpu_starved);
  assign has_grant = g_alu | g_mem | g_fpu;

  always_comb begin
    win = '0;
    if (g_alu)      win = alu_req;
    else if (g_fpu) win = fpu_hold;
    else if (g_mem) win = mem_hold;
  end

  // A grant to general r0 is consumed but never reaches the register file.
  assign wenable = has_grant && !is_greg_zero(win.fmode, win.rd);
  assign wfmode  = win.fmode;
  assign wreg    = win.rd;
  assign wdata   = win.data;

  assign stall_req = mem_starved | fpu_starved;

  function automatic logic slot_hit(input logic v, input wb_req_t h,
                                    input logic f, input logic [4:0] r);
    return v && (h.fmode == f) && (h.rd == r);
  endfunction

  // Entries being written this cycle still report a hit; decode picks the
  // value up from register-file forwarding a cycle later.
  assign pend_hit = !is_greg_zero(pend_fmode, pend_reg) &&
                    (slot_hit(mem_hv, mem_hold, pend_fmode, pend_reg) ||
                     slot_hit(fpu_hv, fpu_hold, pend_fmode, pend_reg));

endmodule
